// File: rtl/regfile_mp_if.sv
// Register-file bus: write/commit, reserve, and multi-port read signals.
// The CPU side uses master; the register file uses slave.
interface regfile_mp_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
);
    logic                     RegWrite;
    logic [ADDR_W-1:0]        Write_register;
    logic [DATA_W-1:0]        Write_data;
    logic                     Reserve;
    logic [ADDR_W-1:0]        Reserve_register;
    logic [NUM_RD*ADDR_W-1:0] Read_register;
    logic [NUM_RD*DATA_W-1:0] Read_data;
    logic [NUM_RD-1:0]        Read_busy;
    logic [ADDR_W:0]          Pending_count;

    modport master (
        output RegWrite, Write_register, Write_data,
        output Reserve, Reserve_register, Read_register,
        input  Read_data, Read_busy, Pending_count
    );

    modport slave (
        input  RegWrite, Write_register, Write_data,
        input  Reserve, Reserve_register, Read_register,
        output Read_data, Read_busy, Pending_count
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-through bypass and a per-register
// pending bit (scoreboard) plus a running count of pending registers.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1
) (
    input logic         clk,
    input logic         reset,
    regfile_mp_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [ADDR_W:0]   count;
    logic              wr_en;
    logic              rs_en;
    logic              inc;
    logic              dec;
    logic [ADDR_W-1:0] rd_addr;

    assign wr_en = bus.RegWrite && !(ZERO_REG != 0 && bus.Write_register == '0);
    assign rs_en = bus.Reserve  && !(ZERO_REG != 0 && bus.Reserve_register == '0);

    // Count moves only on real pending transitions; a reserve of the register
    // being written cancels the write's clear.
    assign inc = rs_en && !pending[bus.Reserve_register];
    assign dec = wr_en && pending[bus.Write_register] &&
                 !(rs_en && bus.Reserve_register == bus.Write_register);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            pending <= '0;
            count   <= '0;
        end else begin
            if (wr_en) begin
                mem[bus.Write_register]     <= bus.Write_data;
                pending[bus.Write_register] <= 1'b0;
            end
            if (rs_en) begin
                pending[bus.Reserve_register] <= 1'b1;
            end
            case ({inc, dec})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign bus.Pending_count = count;

    always_comb begin
        bus.Read_data = '0;
        bus.Read_busy = '0;
        rd_addr       = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_addr = bus.Read_register[k*ADDR_W +: ADDR_W];
            if (ZERO_REG != 0 && rd_addr == '0) begin
                bus.Read_busy[k] = 1'b0;
            end else if (BYPASS != 0 && bus.RegWrite && bus.Write_register == rd_addr) begin
                bus.Read_data[k*DATA_W +: DATA_W] = bus.Write_data;
                bus.Read_busy[k] = 1'b0;
            end else begin
                bus.Read_data[k*DATA_W +: DATA_W] = mem[rd_addr];
                bus.Read_busy[k] = pending[rd_addr];
            end
        end
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: two configurations (bypass+zero-reg, and neither)
// share one stimulus stream and are checked against a behavioural model.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  Write_register;
    logic [31:0] Write_data;
    logic        Reserve;
    logic [4:0]  Reserve_register;
    logic [4:0]  rd [2];

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    // model state per configuration: 0 = BYPASS1/ZERO_REG1, 1 = BYPASS0/ZERO_REG0
    logic [31:0] mmem [2][32];
    bit          mpend [2][32];
    bit          byp [2];
    bit          zr [2];

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifb ();

    assign ifa.RegWrite         = RegWrite;
    assign ifa.Write_register   = Write_register;
    assign ifa.Write_data       = Write_data;
    assign ifa.Reserve          = Reserve;
    assign ifa.Reserve_register = Reserve_register;
    assign ifa.Read_register    = {rd[1], rd[0]};
    assign ifb.RegWrite         = RegWrite;
    assign ifb.Write_register   = Write_register;
    assign ifb.Write_data       = Write_data;
    assign ifb.Reserve          = Reserve;
    assign ifb.Reserve_register = Reserve_register;
    assign ifb.Read_register    = {rd[1], rd[0]};

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] act_data(input int c, input int k);
        return (c == 0) ? ifa.Read_data[k*32 +: 32] : ifb.Read_data[k*32 +: 32];
    endfunction

    function automatic logic act_busy(input int c, input int k);
        return (c == 0) ? ifa.Read_busy[k] : ifb.Read_busy[k];
    endfunction

    function automatic logic [31:0] act_cnt(input int c);
        return (c == 0) ? 32'(ifa.Pending_count) : 32'(ifb.Pending_count);
    endfunction

    // model update: architectural rules applied at each rising edge
    initial begin
        byp[0] = 1'b1; zr[0] = 1'b1;
        byp[1] = 1'b0; zr[1] = 1'b0;
        forever begin
            @(posedge clk);
            for (int c = 0; c < 2; c++) begin
                if (reset) begin
                    for (int r = 0; r < 32; r++) begin
                        mmem[c][r]  = '0;
                        mpend[c][r] = 1'b0;
                    end
                end else begin
                    if (RegWrite && !(zr[c] && Write_register == 0)) begin
                        mmem[c][Write_register]  = Write_data;
                        mpend[c][Write_register] = 1'b0;
                    end
                    if (Reserve && !(zr[c] && Reserve_register == 0))
                        mpend[c][Reserve_register] = 1'b1;
                end
            end
        end
    end

    // compare process: every read port and the count, both configurations
    initial begin
        forever begin
            @(negedge clk);
            if (check_en) begin
                for (int c = 0; c < 2; c++) begin
                    int pc;
                    pc = 0;
                    for (int r = 0; r < 32; r++) pc += int'(mpend[c][r]);
                    for (int k = 0; k < 2; k++) begin
                        logic [31:0] ed;
                        logic        eb;
                        if (zr[c] && rd[k] == 0) begin
                            ed = '0; eb = 1'b0;
                        end else if (byp[c] && RegWrite && Write_register == rd[k]) begin
                            ed = Write_data; eb = 1'b0;
                        end else begin
                            ed = mmem[c][rd[k]]; eb = mpend[c][rd[k]];
                        end
                        chk($sformatf("cfg%0d_port%0d_data", c, k), act_data(c, k), ed);
                        chk($sformatf("cfg%0d_port%0d_busy", c, k), 32'(act_busy(c, k)), 32'(eb));
                    end
                    chk($sformatf("cfg%0d_count", c), act_cnt(c), 32'(pc));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; RegWrite = 1'b0; Reserve = 1'b0;
        Write_register = '0; Write_data = '0; Reserve_register = '0;
        rd[0] = '0; rd[1] = '0;
        tick();
        reset = 1'b0;
        check_en = 1'b1;

        // reset state across every address
        for (int a = 0; a < 32; a++) begin
            rd[0] = 5'(a); rd[1] = 5'(31 - a);
            #1;
            chk("rst_data_a", act_data(0, 0), 32'h0);
            chk("rst_busy_b", 32'(act_busy(1, 1)), 32'h0);
            tick();
        end
        chk("rst_count_a", act_cnt(0), 32'd0);

        // write with bypass vs. no bypass
        RegWrite = 1'b1; Write_register = 5'd5; Write_data = 32'hDEADBEEF; rd[0] = 5'd5;
        #1;
        chk("bypass_same_cycle_a", act_data(0, 0), 32'hDEADBEEF);
        chk("nobypass_same_cycle_b", act_data(1, 0), 32'h0);
        tick();
        RegWrite = 1'b0;
        #1;
        chk("nobypass_next_cycle_b", act_data(1, 0), 32'hDEADBEEF);

        // register zero: hardwired in a, ordinary in b
        RegWrite = 1'b1; Write_register = 5'd0; Write_data = 32'h1234;
        Reserve = 1'b1; Reserve_register = 5'd0; rd[0] = 5'd0;
        tick();
        RegWrite = 1'b0; Reserve = 1'b0;
        #1;
        chk("zero_data_a", act_data(0, 0), 32'h0);
        chk("zero_busy_a", 32'(act_busy(0, 0)), 32'h0);
        chk("zero_count_a", act_cnt(0), 32'd0);
        chk("zero_data_b", act_data(1, 0), 32'h1234);
        chk("zero_count_b", act_cnt(1), 32'd1);

        // scoreboard: reserve 3, 7, 3
        Reserve = 1'b1; Reserve_register = 5'd3;
        tick();
        Reserve = 1'b0;
        #1;
        chk("res3_count_a", act_cnt(0), 32'd1);
        chk("res3_count_b", act_cnt(1), 32'd2);
        Reserve = 1'b1; Reserve_register = 5'd7; rd[1] = 5'd7;
        tick();
        Reserve = 1'b0;
        #1;
        chk("res7_count_a", act_cnt(0), 32'd2);
        chk("res7_busy_a", 32'(act_busy(0, 1)), 32'h1);
        Reserve = 1'b1; Reserve_register = 5'd3;
        tick();
        Reserve = 1'b0;
        #1;
        chk("res3_again_count_a", act_cnt(0), 32'd2);
        chk("res3_again_count_b", act_cnt(1), 32'd3);

        // commit reg 7
        RegWrite = 1'b1; Write_register = 5'd7; Write_data = 32'h55;
        tick();
        RegWrite = 1'b0;
        #1;
        chk("wr7_busy_a", 32'(act_busy(0, 1)), 32'h0);
        chk("wr7_data_a", act_data(0, 1), 32'h55);
        chk("wr7_count_a", act_cnt(0), 32'd1);

        // simultaneous write + reserve of an already-pending register
        Reserve = 1'b1; Reserve_register = 5'd9; rd[0] = 5'd9;
        tick();
        RegWrite = 1'b1; Write_register = 5'd9; Write_data = 32'hABCD;
        tick();
        RegWrite = 1'b0; Reserve = 1'b0;
        #1;
        chk("wr_res_data_a", act_data(0, 0), 32'hABCD);
        chk("wr_res_busy_a", 32'(act_busy(0, 0)), 32'h1);
        chk("wr_res_count_a", act_cnt(0), 32'd2);
        chk("wr_res_count_b", act_cnt(1), 32'd3);

        // reset mid-operation drops reservations and the concurrent write
        for (int r = 10; r < 14; r++) begin
            Reserve = 1'b1; Reserve_register = 5'(r);
            tick();
        end
        Reserve = 1'b0;
        reset = 1'b1; RegWrite = 1'b1; Write_register = 5'd2; Write_data = 32'hFF;
        tick();
        reset = 1'b0; RegWrite = 1'b0; rd[0] = 5'd2; rd[1] = 5'd11;
        #1;
        chk("midrst_count_a", act_cnt(0), 32'd0);
        chk("midrst_count_b", act_cnt(1), 32'd0);
        chk("midrst_data_a", act_data(0, 0), 32'h0);
        chk("midrst_data_b", act_data(1, 0), 32'h0);

        // randomized traffic over a narrow address window to force collisions
        for (int n = 0; n < 3000; n++) begin
            reset            = ($urandom_range(0, 199) == 0);
            RegWrite         = 1'($urandom_range(0, 1));
            Reserve          = 1'($urandom_range(0, 1));
            Write_register   = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            Reserve_register = ($urandom_range(0, 3) == 0) ? Write_register : 5'($urandom_range(0, 7));
            Write_data       = $urandom;
            rd[0]            = ($urandom_range(0, 2) == 0) ? Write_register : 5'($urandom_range(0, 7));
            rd[1]            = ($urandom_range(0, 3) == 0) ? rd[0] : 5'($urandom);
            tick();
        end

        RegWrite = 1'b0; Reserve = 1'b0; reset = 1'b0;
        tick();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
